alu_log_ctrl: RTL and testbench
===============================

ALU_LOG_CTRL -- requirements
Module: alu_log_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_funct  input  6  R-type funct code selecting the logic op.
REQ-007 req_A  input  32  operand A.
REQ-008 req_B  input  32  operand B.
REQ-009 log_A  output  32  operand A driven to the external logic unit (registered).
REQ-010 log_B  output  32  operand B driven to the external logic unit (registered).
REQ-011 AluOp0  output  1  logic unit select bit 0 (registered).
REQ-012 AluOp1  output  1  logic unit select bit 1 (registered).
REQ-013 log_result  input  32  combinational result returned by the logic unit.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts the response.
REQ-016 rsp_result  output  32  captured result.
REQ-017 rsp_err  output  1  request had an illegal funct.
REQ-018 op_count  output  16  completed legal operations, wraps.
REQ-019 err_count  output  8  illegal requests, saturates at 255.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept (req_valid && req_ready) SHALL register req_A/req_B into log_A/log_B and the decoded op into AluOp0/AluOp1.
REQ-022 Decode SHALL be: 0x24 AND -> (AluOp0,AluOp1)=(0,0); 0x25 OR -> (1,0); 0x26 XOR -> (0,1); 0x27 NOR -> (1,1); any other funct illegal.
REQ-023 Legal accept: IDLE->EXEC; in EXEC the next edge SHALL capture log_result into rsp_result, set rsp_err=0, go RESP.
REQ-024 Illegal accept: IDLE->RESP directly, rsp_result=0, rsp_err=1; log_A/log_B/AluOp0/AluOp1 SHALL hold their previous values.
REQ-025 rsp_valid SHALL be 1 exactly in RESP; rsp_result/rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Latency: legal rsp_valid SHALL rise 2 edges after the accept edge; illegal 1 edge after.
REQ-027 RESP with rsp_ready=1 SHALL return to IDLE on that edge; a new request SHALL not be accepted on the same edge (req_ready=0 in RESP).
REQ-028 op_count SHALL increment on a legal response handshake, wrapping 0xFFFF->0x0000.
REQ-029 err_count SHALL increment on an illegal response handshake, holding at 0xFF.
REQ-030 log_A, log_B, AluOp0, AluOp1 SHALL stay constant from accept edge through the EXEC capture edge.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_result=0, rsp_err=0, log_A=0, log_B=0, AluOp0=0, AluOp1=0, op_count=0, err_count=0.
REQ-032 Reset mid-transaction (EXEC or RESP) SHALL drop it with no counter update; req_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-033 A shared package alu_pkg SHALL hold the funct constants (0x24-0x27), the FSM state enum, and the counter widths.
REQ-034 One combinational sub-module alu_funct_dec SHALL map funct[5:0] to AluOp0, AluOp1, illegal.

Verification
REQ-035 Reset: rst pulse mid-cycle -> all outputs 0 asynchronously; req_ready=1 one edge after release.
REQ-036 AND: A=0xF0F0F0F0, B=0xFF00FF00, funct=0x24, model returns A&B -> AluOp=(0,0), rsp_result=0xF000F000 two edges after accept, op_count=1.
REQ-037 NOR with backpressure: A=0, B=0x0000FFFF, funct=0x27, rsp_ready=0 for 5 cycles -> AluOp=(1,1), rsp_result=0xFFFF0000 held stable, req_ready=0 throughout.
REQ-038 Illegal: funct=0x20 -> rsp_valid one edge after accept, rsp_err=1, rsp_result=0, AluOp unchanged, err_count=1; 300 illegal ops -> err_count=255.
REQ-039 Wrap: preload 65535 legal ops (or force counter), one more XOR 0x26 -> op_count=0x0000.
REQ-040 Reset in EXEC: assert rst after accept of OR 0x25 -> no rsp_valid, op_count unchanged at 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the logic-op request controller: funct codes,
// FSM state type and counter widths.
package alu_pkg;

    // R-type funct codes for the four logic operations
    localparam logic [5:0] FunctAnd = 6'h24;
    localparam logic [5:0] FunctOr  = 6'h25;
    localparam logic [5:0] FunctXor = 6'h26;
    localparam logic [5:0] FunctNor = 6'h27;

    localparam int unsigned OpCntW  = 16;
    localparam int unsigned ErrCntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational funct decoder: maps a 6-bit R-type funct code onto the
// two logic-unit select bits, flagging anything outside the logic group.
module alu_funct_dec
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic       alu_op0,
    output logic       alu_op1,
    output logic       illegal
);

    // Decode table; unknown codes select AND but are flagged illegal
    always_comb begin
        alu_op0 = 1'b0;
        alu_op1 = 1'b0;
        illegal = 1'b0;
        case (funct)
            FunctAnd: begin
                alu_op0 = 1'b0;
                alu_op1 = 1'b0;
            end
            FunctOr: begin
                alu_op0 = 1'b1;
            end
            FunctXor: begin
                alu_op1 = 1'b1;
            end
            FunctNor: begin
                alu_op0 = 1'b1;
                alu_op1 = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_log_ctrl.sv
// Request/response controller for an external combinational logic unit.
// A legal request registers its operands and op select, waits one cycle
// for the unit to settle, captures the result and presents it until the
// consumer accepts. Illegal requests skip the unit and respond with an error.
module alu_log_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_funct,
    input  logic [31:0]        req_A,
    input  logic [31:0]        req_B,
    output logic [31:0]        log_A,
    output logic [31:0]        log_B,
    output logic               AluOp0,
    output logic               AluOp1,
    input  logic [31:0]        log_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_err,
    output logic [OpCntW-1:0]  op_count,
    output logic [ErrCntW-1:0] err_count
);

    state_e               state_q;
    logic [OpCntW-1:0]    op_cnt_q;
    logic [ErrCntW-1:0]   err_cnt_q;
    logic                 dec_op0;
    logic                 dec_op1;
    logic                 dec_illegal;
    logic                 accept;

    alu_funct_dec u_dec (
        .funct   (req_funct),
        .alu_op0 (dec_op0),
        .alu_op1 (dec_op1),
        .illegal (dec_illegal)
    );

    // req_ready is registered, so it can only be high in an idle state
    assign accept    = req_valid && req_ready;
    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;

    // Transaction FSM; all handshake and datapath outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            log_A      <= '0;
            log_B      <= '0;
            AluOp0     <= 1'b0;
            AluOp1     <= 1'b0;
            op_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (dec_illegal) begin
                            // Operand/op registers keep the last legal request
                            state_q    <= StResp;
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end else begin
                            state_q <= StExec;
                            log_A   <= req_A;
                            log_B   <= req_B;
                            AluOp0  <= dec_op0;
                            AluOp1  <= dec_op1;
                        end
                    end else begin
                        // First edge after reset release raises ready here
                        req_ready <= 1'b1;
                    end
                end
                StExec: begin
                    state_q    <= StResp;
                    rsp_valid  <= 1'b1;
                    rsp_result <= log_result;
                    rsp_err    <= 1'b0;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        if (rsp_err) begin
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                        end else begin
                            op_cnt_q <= op_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_log_ctrl.sv
// Self-checking bench for alu_log_ctrl with a behavioural logic unit and a
// transaction-level reference model.
module tb_alu_log_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_A;
    logic [31:0] req_B;
    logic [31:0] log_A;
    logic [31:0] log_B;
    logic        AluOp0;
    logic        AluOp1;
    logic [31:0] log_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [15:0] op_count;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_op;
    int          m_err;
    logic [31:0] m_log_a;
    logic [31:0] m_log_b;
    logic        m_op0;
    logic        m_op1;

    alu_log_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_A      (req_A),
        .req_B      (req_B),
        .log_A      (log_A),
        .log_B      (log_B),
        .AluOp0     (AluOp0),
        .AluOp1     (AluOp1),
        .log_result (log_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .op_count   (op_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External logic unit: select bits (AluOp1,AluOp0) 00 AND, 01 OR, 10 XOR, 11 NOR
    always_comb begin
        case ({AluOp1, AluOp0})
            2'b00:   log_result = log_A & log_B;
            2'b01:   log_result = log_A | log_B;
            2'b10:   log_result = log_A ^ log_B;
            default: log_result = ~(log_A | log_B);
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_op    = 0;
        m_err   = 0;
        m_log_a = '0;
        m_log_b = '0;
        m_op0   = 1'b0;
        m_op1   = 1'b0;
    endtask

    // Architectural meaning of a funct code
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, output logic legal,
                                   output logic op0, output logic op1,
                                   output logic [31:0] r);
        legal = 1'b1;
        op0   = 1'b0;
        op1   = 1'b0;
        r     = '0;
        if (f == 6'h24) r = a & b;
        else if (f == 6'h25) begin r = a | b; op0 = 1'b1; end
        else if (f == 6'h26) begin r = a ^ b; op1 = 1'b1; end
        else if (f == 6'h27) begin r = ~(a | b); op0 = 1'b1; op1 = 1'b1; end
        else legal = 1'b0;
    endfunction

    // One full transaction: accept, latency, backpressure hold, handshake, counters
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic        legal;
        logic        e0;
        logic        e1;
        logic [31:0] er;
        logic [31:0] exp_res;
        int          n;
        ref_op(f, a, b, legal, e0, e1, er);
        exp_res = legal ? er : 32'h0;
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: req_ready=%b expected 1", tag, req_ready);
        end
        req_valid = 1'b1;
        req_funct = f;
        req_A     = a;
        req_B     = b;
        step();
        // Noise on the request side must not be picked up before the handshake
        req_valid = 1'($urandom);
        req_funct = 6'($urandom);
        req_A     = $urandom;
        req_B     = $urandom;
        if (legal) begin
            m_log_a = a;
            m_log_b = b;
            m_op0   = e0;
            m_op1   = e1;
        end
        checks++;
        if ({req_ready, rsp_valid} !== {1'b0, !legal}) begin
            errors++;
            $display("FAIL %s accept_hs: ready,valid=%b%b expected 0%b", tag, req_ready,
                     rsp_valid, !legal);
        end
        checks++;
        if ({log_A, log_B, AluOp0, AluOp1} !== {m_log_a, m_log_b, m_op0, m_op1}) begin
            errors++;
            $display("FAIL %s operands: A=%h B=%h op=%b%b expected A=%h B=%h op=%b%b", tag,
                     log_A, log_B, AluOp0, AluOp1, m_log_a, m_log_b, m_op0, m_op1);
        end
        if (legal) begin
            step();
            checks++;
            if ({log_A, log_B, AluOp0, AluOp1} !== {m_log_a, m_log_b, m_op0, m_op1}) begin
                errors++;
                $display("FAIL %s operands_exec: A=%h B=%h expected A=%h B=%h", tag, log_A,
                         log_B, m_log_a, m_log_b);
            end
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, !legal, exp_res}) begin
            errors++;
            $display("FAIL %s response: valid=%b err=%b result=%h expected 1 %b %h", tag,
                     rsp_valid, rsp_err, rsp_result, !legal, exp_res);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            checks++;
            if ({rsp_valid, rsp_err, rsp_result, req_ready} !== {1'b1, !legal, exp_res, 1'b0})
            begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b err=%b result=%h ready=%b expected 1 %b %h 0",
                         tag, i, rsp_valid, rsp_err, rsp_result, req_ready, !legal, exp_res);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        if (legal) m_op = (m_op + 1) % 65536;
        else if (m_err < 255) m_err = m_err + 1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s handshake: valid=%b ready=%b expected 0 1", tag, rsp_valid,
                     req_ready);
        end
        checks++;
        if ({op_count, err_count} !== {16'(m_op), 8'(m_err)}) begin
            errors++;
            $display("FAIL %s counters: op=%0d err=%0d expected op=%0d err=%0d", tag, op_count,
                     err_count, m_op, m_err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_funct = '0;
        req_A     = '0;
        req_B     = '0;
        rsp_ready = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, AluOp0, AluOp1, rsp_result, log_A, log_B,
             op_count, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b err=%b res=%h A=%h B=%h op=%0d e=%0d",
                     req_ready, rsp_valid, rsp_err, rsp_result, log_A, log_B, op_count,
                     err_count);
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: req_ready=%b expected 0", req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_ready: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_reset_in_exec();
        req_valid = 1'b1;
        req_funct = 6'h25;
        req_A     = 32'h1234_5678;
        req_B     = 32'h0F0F_0000;
        step();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, log_A, AluOp0} !== {1'b0, 32'h1234_5678, 1'b1}) begin
            errors++;
            $display("FAIL exec_rst_accept: valid=%b A=%h op0=%b expected 0 12345678 1",
                     rsp_valid, log_A, AluOp0);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, AluOp0, AluOp1, rsp_result, log_A, log_B,
             op_count, err_count} !== '0) begin
            errors++;
            $display("FAIL exec_rst_async: ready=%b valid=%b A=%h B=%h op=%b%b", req_ready,
                     rsp_valid, log_A, log_B, AluOp0, AluOp1);
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL exec_rst_ready: req_ready=%b expected 1", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, op_count} !== {1'b0, 16'h0}) begin
                errors++;
                $display("FAIL exec_rst_dropped: valid=%b op=%0d expected 0 0", rsp_valid,
                         op_count);
            end
            step();
        end
    endtask

    task automatic test_and();
        run_op(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, "and");
        checks++;
        if ({rsp_result, op_count} !== {32'hF000_F000, 16'd1}) begin
            errors++;
            $display("FAIL and_result: result=%h op=%0d expected f000f000 1", rsp_result,
                     op_count);
        end
    endtask

    task automatic test_nor_backpressure();
        run_op(6'h27, 32'h0, 32'h0000_FFFF, 5, "nor_bp");
        checks++;
        if ({rsp_result, AluOp0, AluOp1} !== {32'hFFFF_0000, 2'b11}) begin
            errors++;
            $display("FAIL nor_result: result=%h op=%b%b expected ffff0000 11", rsp_result,
                     AluOp0, AluOp1);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] f;
        run_op(6'h20, $urandom, $urandom, 2, "illegal_first");
        for (int i = 0; i < 300; i++) begin
            do f = 6'($urandom_range(0, 63)); while (f >= 6'h24 && f <= 6'h27);
            run_op(f, $urandom, $urandom, 0, "illegal_loop");
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: err_count=%0d expected 255", err_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] f;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) f = 6'($urandom);
            else f = 6'(6'h24 + $urandom_range(0, 3));
            run_op(f, $urandom, $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 0, "b2b_xor");
        run_op(6'h25, 32'h0000_00F0, 32'h0F00_0000, 0, "b2b_or");
        run_op(6'h3F, 32'h1111_1111, 32'h2222_2222, 0, "b2b_bad");
        run_op(6'h24, 32'hDEAD_BEEF, 32'h0000_FFFF, 0, "b2b_and");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        m_op = 65535;
        step();
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: op_count=%h expected ffff", op_count);
        end
        run_op(6'h26, 32'h0123_4567, 32'h89AB_CDEF, 1, "wrap_xor");
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: op_count=%h expected 0000", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_in_exec();
        test_and();
        test_nor_backpressure();
        test_illegal();
        test_random();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
